rx_destuffer: RTL and testbench

- Receive-side counterpart of the serial bit-stuffing transmitter path.
- Recovers bit timing from the serial input using the shared baud divisor.
- Hunts for 0x7E flags, removes stuffed zeros and assembles LSB-first bytes into a receive FIFO.
- Reports frame end, abort, framing error and overrun to the CPU-side status and interrupt logic.

---
 rtl/rx_destuffer_pkg.sv | 23 ++
 rtl/rx_fifo.sv | 57 +++++
 rtl/rx_destuffer.sv | 175 +++++++++++++++++
 tb/tb_rx_destuffer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_destuffer_pkg.sv
// Shared definitions for the bit-stuffed serial link (transmit and receive sides).
package rx_destuffer_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    DATA = 1'b1
  } state_e;

  typedef logic [7:0] byte_t;

  localparam byte_t FLAG_BYTE  = 8'h7E;
  localparam int    STUFF_ONES = 5;
  localparam int    ABORT_ONES = 7;
  // Run of ones inside a flag: a zero after exactly this many ones closes/opens a frame.
  localparam int    FLAG_ONES  = $countones(FLAG_BYTE);

  function automatic logic [2:0] ones_next(input logic [2:0] ones, input logic rx_bit);
    if (!rx_bit) return 3'd0;
    if (ones == 3'(ABORT_ONES)) return ones;
    return ones + 3'd1;
  endfunction

endpackage

// File: rtl/rx_fifo.sv
// First-word-fall-through receive FIFO; head is visible on dout while not empty, 0 otherwise.
module rx_fifo
  import rx_destuffer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          push,
  input  byte_t         push_data,
  input  logic          pop,
  output byte_t         dout,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  byte_t         mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;
  assign dout  = empty ? 8'h00 : mem_q[rd_ptr_q];

endmodule

// File: rtl/rx_destuffer.sv
// Serial receiver: bit-timing recovery, flag hunt, zero destuffing and byte assembly into a FIFO.
module rx_destuffer
  import rx_destuffer_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          EN,
  input  logic          RX,
  input  logic [7:0]    BAUD,
  input  logic          RD,
  input  logic          CLR_ERR,
  output logic [7:0]    DOUT,
  output logic          AVAIL,
  output logic          FULL,
  output logic [CW-1:0] COUNT,
  output logic          FRAME_END,
  output logic          ABORT,
  output logic          FRAME_ERR,
  output logic          OVERRUN
);

  // rx_sync_q[1] is the synchronised line, rx_sync_q[2] its previous value.
  logic [2:0] rx_sync_q, rx_sync_d;
  logic [7:0] timer_q, timer_d;
  state_e     state_q, state_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [2:0] ones_q, ones_d;
  byte_t      shift_q, shift_d;
  logic       frame_nonempty_q, frame_nonempty_d;
  logic       frame_end_q, frame_end_d;
  logic       abort_q, abort_d;
  logic       frame_err_q, frame_err_d;
  logic       overrun_q, overrun_d;

  logic       active, rx_edge, rx_bit, strobe;
  logic       push, abort_set, ferr_set, overrun_set;
  byte_t      shift_v;
  logic       fifo_empty, fifo_full;

  always_comb begin
    rx_sync_d = {rx_sync_q[1:0], RX};
    rx_bit    = rx_sync_q[1];
    rx_edge   = rx_sync_q[2] ^ rx_sync_q[1];
    active    = EN && (BAUD != 8'd0);

    strobe  = 1'b0;
    timer_d = timer_q;
    // Every line transition re-centres the sample point half a bit later.
    if (!active || rx_edge) begin
      timer_d = BAUD >> 1;
    end else if (timer_q == 8'd0) begin
      strobe  = 1'b1;
      timer_d = BAUD;
    end else begin
      timer_d = timer_q - 8'd1;
    end
  end

  always_comb begin
    state_d          = state_q;
    bitcnt_d         = bitcnt_q;
    ones_d           = ones_q;
    shift_d          = shift_q;
    shift_v          = shift_q;
    frame_nonempty_d = frame_nonempty_q;
    frame_end_d      = 1'b0;
    push             = 1'b0;
    abort_set        = 1'b0;
    ferr_set         = 1'b0;

    if (!active) begin
      state_d  = HUNT;
      bitcnt_d = 3'd0;
      ones_d   = 3'd0;
    end else if (strobe) begin
      ones_d = ones_next(ones_q, rx_bit);
      if (state_q == HUNT) begin
        if (!rx_bit && ones_q == 3'(FLAG_ONES)) begin
          state_d          = DATA;
          bitcnt_d         = 3'd0;
          frame_nonempty_d = 1'b0;
        end
      end else begin
        if (!rx_bit && ones_q == 3'(STUFF_ONES)) begin
          ones_d = 3'd0;
        end else if (!rx_bit && ones_q == 3'(FLAG_ONES)) begin
          // The flag's leading 0 and six ones were shifted in as data; drop them.
          if (bitcnt_q == 3'd7) begin
            frame_end_d = frame_nonempty_q;
          end else begin
            ferr_set = frame_nonempty_q;
          end
          bitcnt_d         = 3'd0;
          frame_nonempty_d = 1'b0;
        end else if (rx_bit && ones_q == 3'(FLAG_ONES)) begin
          abort_set = 1'b1;
          state_d   = HUNT;
          bitcnt_d  = 3'd0;
        end else begin
          shift_v[bitcnt_q] = rx_bit;
          shift_d           = shift_v;
          if (bitcnt_q == 3'd7) begin
            push             = 1'b1;
            bitcnt_d         = 3'd0;
            frame_nonempty_d = 1'b1;
          end else begin
            bitcnt_d = bitcnt_q + 3'd1;
          end
        end
      end
    end
  end

  always_comb begin
    overrun_set = push && fifo_full && !RD;
    // Set events take priority over a simultaneous clear.
    abort_d     = abort_set   | (abort_q     & ~CLR_ERR);
    frame_err_d = ferr_set    | (frame_err_q & ~CLR_ERR);
    overrun_d   = overrun_set | (overrun_q   & ~CLR_ERR);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_sync_q        <= 3'b000;
      timer_q          <= 8'd0;
      state_q          <= HUNT;
      bitcnt_q         <= 3'd0;
      ones_q           <= 3'd0;
      shift_q          <= 8'h00;
      frame_nonempty_q <= 1'b0;
      frame_end_q      <= 1'b0;
      abort_q          <= 1'b0;
      frame_err_q      <= 1'b0;
      overrun_q        <= 1'b0;
    end else begin
      rx_sync_q        <= rx_sync_d;
      timer_q          <= timer_d;
      state_q          <= state_d;
      bitcnt_q         <= bitcnt_d;
      ones_q           <= ones_d;
      shift_q          <= shift_d;
      frame_nonempty_q <= frame_nonempty_d;
      frame_end_q      <= frame_end_d;
      abort_q          <= abort_d;
      frame_err_q      <= frame_err_d;
      overrun_q        <= overrun_d;
    end
  end

  rx_fifo #(
    .DEPTH(FIFO_DEPTH),
    .CW   (CW)
  ) u_fifo (
    .CLK      (CLK),
    .RST      (RST),
    .push     (push),
    .push_data(shift_v),
    .pop      (RD),
    .dout     (DOUT),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .count    (COUNT)
  );

  assign AVAIL     = ~fifo_empty;
  assign FULL      = fifo_full;
  assign FRAME_END = frame_end_q;
  assign ABORT     = abort_q;
  assign FRAME_ERR = frame_err_q;
  assign OVERRUN   = overrun_q;

endmodule

// File: tb/tb_rx_destuffer.sv
// Directed bench for rx_destuffer: drives a bit-stuffed serial line and checks FIFO and status.
module tb_rx_destuffer;
  import rx_destuffer_pkg::*;

  logic       CLK = 1'b0;
  logic       RST, EN, RX, RD, CLR_ERR;
  logic [7:0] BAUD;
  logic [7:0] DOUT;
  logic       AVAIL, FULL, FRAME_END, ABORT, FRAME_ERR, OVERRUN;
  logic [4:0] COUNT;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   fe_count = 0;
  logic ovr_seen = 1'b0;
  int   tx_ones  = 0;
  int   jit_prev = 0;
  logic jitter_on = 1'b0;

  rx_destuffer #(.FIFO_DEPTH(16)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .RX(RX), .BAUD(BAUD), .RD(RD), .CLR_ERR(CLR_ERR),
    .DOUT(DOUT), .AVAIL(AVAIL), .FULL(FULL), .COUNT(COUNT), .FRAME_END(FRAME_END),
    .ABORT(ABORT), .FRAME_ERR(FRAME_ERR), .OVERRUN(OVERRUN)
  );

  always #5 CLK = ~CLK;

  // OVERRUN high while CLR_ERR was held on the updating edge means the set beat the clear.
  always @(negedge CLK) begin
    if (FRAME_END) fe_count++;
    if (CLR_ERR && OVERRUN) ovr_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clk(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_bit(input logic b);
    int d;
    int j;
    d = int'(BAUD) + 1;
    if (jitter_on) begin
      j = int'($urandom_range(2)) - 1;
      d = d + j - jit_prev;
      jit_prev = j;
    end
    RX = b;
    clk(d);
  endtask

  task automatic send_raw(input byte_t v, input int n);
    for (int i = 0; i < n; i++) send_bit(v[i]);
  endtask

  task automatic send_flag();
    byte_t f;
    f = FLAG_BYTE;
    for (int i = 0; i < 8; i++) send_bit(f[i]);
    tx_ones = 0;
  endtask

  task automatic send_byte(input byte_t v);
    for (int i = 0; i < 8; i++) begin
      send_bit(v[i]);
      tx_ones = v[i] ? tx_ones + 1 : 0;
      if (tx_ones == 5) begin
        send_bit(1'b0);
        tx_ones = 0;
      end
    end
  endtask

  task automatic start_rx();
    EN = 1'b1;
    fe_count = 0;
    for (int i = 0; i < 4; i++) send_bit(1'b1);
  endtask

  // Let the closing flag's last bit be sampled, then park the receiver.
  task automatic end_frame();
    clk(2 * (int'(BAUD) + 1));
    EN = 1'b0;
    clk(2);
  endtask

  task automatic pop();
    RD = 1'b1;
    clk(1);
    RD = 1'b0;
  endtask

  task automatic pulse_clr();
    CLR_ERR = 1'b1;
    clk(1);
    CLR_ERR = 1'b0;
  endtask

  initial begin
    RST = 1'b1; EN = 1'b0; RX = 1'b1; BAUD = 8'd3; RD = 1'b0; CLR_ERR = 1'b0;
    clk(3);
    RST = 1'b0;
    clk(2);
    check("rst_dout", 32'(DOUT), 32'h00);
    check("rst_avail", 32'(AVAIL), 32'd0);
    check("rst_full", 32'(FULL), 32'd0);
    check("rst_count", 32'(COUNT), 32'd0);
    check("rst_frame_end", 32'(FRAME_END), 32'd0);
    check("rst_abort", 32'(ABORT), 32'd0);
    check("rst_frame_err", 32'(FRAME_ERR), 32'd0);
    check("rst_overrun", 32'(OVERRUN), 32'd0);

    // Single byte frame.
    start_rx();
    send_flag(); send_byte(8'h41); send_flag();
    end_frame();
    $display("frame 1: flag 41 flag -> dout=%0h count=%0d frame_end=%0d", DOUT, COUNT, fe_count);
    check("t1_dout", 32'(DOUT), 32'h41);
    check("t1_avail", 32'(AVAIL), 32'd1);
    check("t1_count", 32'(COUNT), 32'd1);
    check("t1_frame_end", 32'(fe_count), 32'd1);
    check("t1_abort", 32'(ABORT), 32'd0);
    check("t1_frame_err", 32'(FRAME_ERR), 32'd0);
    check("t1_overrun", 32'(OVERRUN), 32'd0);
    pop();
    check("t1_empty", 32'(AVAIL), 32'd0);

    // Stuffed zeros inside 0xFF and 0x7E.
    start_rx();
    send_flag(); send_byte(8'hFF); send_byte(8'h7E); send_flag();
    end_frame();
    $display("frame 2: flag FF 7E flag -> count=%0d frame_end=%0d", COUNT, fe_count);
    check("t2_count", 32'(COUNT), 32'd2);
    check("t2_dout0", 32'(DOUT), 32'hFF);
    pop();
    check("t2_dout1", 32'(DOUT), 32'h7E);
    pop();
    check("t2_empty", 32'(AVAIL), 32'd0);
    check("t2_frame_end", 32'(fe_count), 32'd1);
    check("t2_errs", 32'({ABORT, FRAME_ERR, OVERRUN}), 32'd0);

    // Abort, unflagged data ignored, then a clean frame.
    start_rx();
    send_flag(); send_byte(8'h12); send_raw(8'hFF, 8);
    $display("frame 3a: flag 12 + eight ones -> abort=%0d count=%0d", ABORT, COUNT);
    check("t3_abort", 32'(ABORT), 32'd1);
    check("t3_no_frame_end", 32'(fe_count), 32'd0);
    check("t3_count_a", 32'(COUNT), 32'd1);
    send_raw(8'h34, 8);
    check("t3_hunt_ignores", 32'(COUNT), 32'd1);
    send_flag(); send_byte(8'h34); send_flag();
    end_frame();
    $display("frame 3b: flag 34 flag -> count=%0d frame_end=%0d", COUNT, fe_count);
    check("t3_count_b", 32'(COUNT), 32'd2);
    check("t3_dout0", 32'(DOUT), 32'h12);
    pop();
    check("t3_dout1", 32'(DOUT), 32'h34);
    pop();
    check("t3_frame_end", 32'(fe_count), 32'd1);
    pulse_clr();
    check("t3_abort_clr", 32'(ABORT), 32'd0);

    // Overrun: 17 bytes into a 16-entry FIFO.
    start_rx();
    send_flag();
    for (int i = 0; i <= 16; i++) send_byte(byte_t'(i));
    send_flag();
    end_frame();
    $display("frame 4: flag 00..10 flag -> count=%0d full=%0d overrun=%0d", COUNT, FULL, OVERRUN);
    check("t4_count", 32'(COUNT), 32'd16);
    check("t4_full", 32'(FULL), 32'd1);
    check("t4_overrun", 32'(OVERRUN), 32'd1);
    check("t4_frame_end", 32'(fe_count), 32'd1);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("t4_pop%0d", i), 32'(DOUT), 32'(i));
      pop();
    end
    check("t4_empty", 32'(AVAIL), 32'd0);
    check("t4_dout_empty", 32'(DOUT), 32'h00);
    pulse_clr();
    check("t4_overrun_clr", 32'(OVERRUN), 32'd0);

    // Overrun arriving while CLR_ERR is held.
    CLR_ERR = 1'b1;
    ovr_seen = 1'b0;
    start_rx();
    send_flag();
    for (int i = 0; i <= 16; i++) send_byte(byte_t'(i));
    send_flag();
    end_frame();
    $display("frame 5: overflow under CLR_ERR -> seen=%0d", ovr_seen);
    check("t5_set_wins", 32'(ovr_seen), 32'd1);
    check("t5_cleared_after", 32'(OVERRUN), 32'd0);
    CLR_ERR = 1'b0;
    for (int i = 0; i < 16; i++) pop();
    check("t5_drained", 32'(COUNT), 32'd0);

    // Misaligned closing flag; the flag bits complete one extra byte (1010 0111 -> 0xE5).
    start_rx();
    send_flag(); send_byte(8'h55); send_raw(8'h05, 4); send_flag();
    end_frame();
    $display("frame 6: flag 55 +4 bits flag -> frame_err=%0d count=%0d", FRAME_ERR, COUNT);
    check("t6_frame_err", 32'(FRAME_ERR), 32'd1);
    check("t6_no_frame_end", 32'(fe_count), 32'd0);
    check("t6_count", 32'(COUNT), 32'd2);
    check("t6_dout0", 32'(DOUT), 32'h55);
    pop();
    check("t6_dout1", 32'(DOUT), 32'hE5);
    pulse_clr();

    // Back-to-back flags.
    start_rx();
    send_flag(); send_flag();
    end_frame();
    $display("frame 7: flag flag -> frame_end=%0d", fe_count);
    check("t7_frame_end", 32'(fe_count), 32'd0);
    check("t7_errs", 32'({ABORT, FRAME_ERR, OVERRUN}), 32'd0);
    check("t7_count", 32'(COUNT), 32'd1);

    // Asynchronous reset mid-frame with ABORT set and FIFO occupied.
    start_rx();
    send_flag(); send_raw(8'hFF, 8);
    send_flag(); send_raw(8'h0D, 4);
    check("t8_pre_abort", 32'(ABORT), 32'd1);
    RST = 1'b1;
    #1;
    $display("reset: dout=%0h avail=%0d count=%0d abort=%0d", DOUT, AVAIL, COUNT, ABORT);
    check("t8_dout", 32'(DOUT), 32'h00);
    check("t8_avail", 32'(AVAIL), 32'd0);
    check("t8_count", 32'(COUNT), 32'd0);
    check("t8_abort", 32'(ABORT), 32'd0);
    EN = 1'b0;
    BAUD = 8'd7;
    clk(3);
    RST = 1'b0;
    clk(2);

    // No leading flag, then a jittered frame at BAUD=7.
    jitter_on = 1'b1;
    start_rx();
    send_raw(8'hA5, 8); send_raw(8'h3C, 8);
    check("t9_no_flag", 32'(AVAIL), 32'd0);
    send_flag(); send_byte(8'h5A); send_byte(8'hC3); send_flag();
    end_frame();
    $display("frame 9: jitter flag 5A C3 flag -> count=%0d frame_end=%0d", COUNT, fe_count);
    check("t9_count", 32'(COUNT), 32'd2);
    check("t9_dout0", 32'(DOUT), 32'h5A);
    pop();
    check("t9_dout1", 32'(DOUT), 32'hC3);
    check("t9_frame_end", 32'(fe_count), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
